// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation encodings,
// FSM state constants and small operation-decode helpers.
package hilo_muldiv_pkg;

    // Operation encodings also used by the control and hazard units
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    // FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // MULT, MULTU, DIV and DIVU all occupy the low half of the encoding space
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    // DIV and DIVU
    function automatic logic is_div_op(input logic [2:0] op);
        return (op[2] == 1'b0) && op[1];
    endfunction

    // MULT and DIV treat their operands as two's complement
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op[2] == 1'b0) && (op[0] == 1'b0);
    endfunction

endpackage

// File: rtl/hilo_muldiv_step.sv
// Combinational single radix-2 iteration on the {acc,q} register pair:
// shift-add for multiply, restoring compare-subtract for divide.
module muldiv_step #(
    parameter int NBITS = 32
) (
    input  logic             is_div,
    input  logic [NBITS:0]   acc,
    input  logic [NBITS-1:0] q,
    input  logic [NBITS-1:0] m,
    output logic [NBITS:0]   acc_next,
    output logic [NBITS-1:0] q_next
);

    logic [NBITS:0]   sum;
    logic [NBITS:0]   shl;
    logic [NBITS+1:0] diff;

    // One iteration: multiply adds the multiplicand when the current multiplier
    // bit is set and shifts right; divide shifts left and keeps the trial
    // subtraction only when it does not go negative.
    always_comb begin
        sum  = acc + {1'b0, m};
        shl  = {acc[NBITS-1:0], q[NBITS-1]};
        diff = {1'b0, shl} - {2'b00, m};
        acc_next = acc;
        q_next   = q;
        if (!is_div) begin
            if (q[0]) begin
                {acc_next, q_next} = {sum, q} >> 1;
            end else begin
                {acc_next, q_next} = {acc, q} >> 1;
            end
        end else begin
            if (!diff[NBITS+1]) begin
                acc_next = diff[NBITS:0];
                q_next   = {q[NBITS-2:0], 1'b1};
            end else begin
                acc_next = shl;
                q_next   = {q[NBITS-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO registers. Operands are
// reduced to magnitudes at launch, iterated one bit per cycle, and the signs
// are restored in a final FIX cycle before HI/LO are written.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int NBITS  = 32,
    parameter int OPBITS = 3,
    parameter int CBITS  = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_Start,
    input  logic [OPBITS-1:0] i_Op,
    input  logic [NBITS-1:0]  i_RegA,
    input  logic [NBITS-1:0]  i_RegB,
    input  logic              i_Flush,
    output logic              o_Busy,
    output logic              o_Done,
    output logic [NBITS-1:0]  o_Hi,
    output logic [NBITS-1:0]  o_Lo
);

    // Control state
    logic [1:0]       state;
    logic [CBITS-1:0] count;
    logic             busy;
    logic             done;
    logic [NBITS-1:0] hi;
    logic [NBITS-1:0] lo;

    // Datapath state (no reset needed: always loaded at launch before use)
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic             div_zero;
    logic [NBITS-1:0] a_raw;
    logic [NBITS-1:0] m;
    logic [NBITS:0]   acc;
    logic [NBITS-1:0] q;

    logic [NBITS:0]   acc_next;
    logic [NBITS-1:0] q_next;

    logic [2:0]       op;
    logic             op_signed;
    logic             op_div;
    logic             a_sgn;
    logic             b_sgn;
    logic             idle_start;
    logic             launch;
    logic             move_hi;
    logic             move_lo;
    logic [NBITS-1:0] fix_hi;
    logic [NBITS-1:0] fix_lo;

    // Magnitude of a possibly signed operand, formed at NBITS+1 bits so the
    // most negative value maps to its correct unsigned magnitude.
    function automatic logic [NBITS-1:0] magnitude(input logic [NBITS-1:0] v,
                                                   input logic             sgn);
        logic [NBITS:0] ext;
        ext = {sgn & v[NBITS-1], v};
        if (ext[NBITS]) begin
            ext = -ext;
        end
        return ext[NBITS-1:0];
    endfunction

    function automatic logic [2*NBITS-1:0] cond_neg_wide(input logic [2*NBITS-1:0] v,
                                                         input logic               n);
        return n ? -v : v;
    endfunction

    function automatic logic [NBITS-1:0] cond_neg(input logic [NBITS-1:0] v,
                                                  input logic             n);
        return n ? -v : v;
    endfunction

    assign op         = i_Op[2:0];
    assign op_signed  = is_signed_op(op);
    assign op_div     = is_div_op(op);
    assign a_sgn      = op_signed & i_RegA[NBITS-1];
    assign b_sgn      = op_signed & i_RegB[NBITS-1];

    // A flush in the same cycle as a start suppresses the start entirely
    assign idle_start = (state == ST_IDLE) && i_Start && !i_Flush;
    assign launch     = idle_start && is_arith_op(op);
    assign move_hi    = idle_start && (op == OP_MTHI);
    assign move_lo    = idle_start && (op == OP_MTLO);

    muldiv_step #(
        .NBITS(NBITS)
    ) u_step (
        .is_div  (is_div),
        .acc     (acc),
        .q       (q),
        .m       (m),
        .acc_next(acc_next),
        .q_next  (q_next)
    );

    // Sign restoration and the divide-by-zero override applied in FIX
    always_comb begin
        logic [2*NBITS-1:0] product;
        product = cond_neg_wide({acc[NBITS-1:0], q}, neg_res);
        fix_hi  = product[2*NBITS-1:NBITS];
        fix_lo  = product[NBITS-1:0];
        if (div_zero) begin
            fix_hi = a_raw;
            fix_lo = '1;
        end else if (is_div) begin
            fix_hi = cond_neg(acc[NBITS-1:0], neg_rem);
            fix_lo = cond_neg(q, neg_res);
        end
    end

    // Operand latch at launch, then one iteration per CALC cycle
    always_ff @(posedge i_clk) begin
        if (launch) begin
            a_raw    <= i_RegA;
            is_div   <= op_div;
            neg_res  <= a_sgn ^ b_sgn;
            neg_rem  <= a_sgn;
            div_zero <= op_div && (i_RegB == '0);
            acc      <= '0;
            if (op_div) begin
                q <= magnitude(i_RegA, op_signed);
                m <= magnitude(i_RegB, op_signed);
            end else begin
                q <= magnitude(i_RegB, op_signed);
                m <= magnitude(i_RegA, op_signed);
            end
        end else if (state == ST_CALC) begin
            acc <= acc_next;
            q   <= q_next;
        end
    end

    // FSM, iteration counter, status flags and the architectural HI/LO
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state <= ST_CALC;
                        count <= CBITS'(NBITS);
                        busy  <= 1'b1;
                    end else if (move_hi) begin
                        hi <= i_RegA;
                    end else if (move_lo) begin
                        lo <= i_RegA;
                    end
                end
                ST_CALC: begin
                    if (i_Flush) begin
                        state <= ST_IDLE;
                        count <= '0;
                        busy  <= 1'b0;
                    end else begin
                        count <= count - 1'b1;
                        if (count == CBITS'(1)) begin
                            state <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    count <= '0;
                    busy  <= 1'b0;
                    if (!i_Flush) begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    count <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_Busy = busy;
    assign o_Done = done;
    assign o_Hi   = hi;
    assign o_Lo   = lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: a cycle-level behavioural model computes
// HI/LO with plain 64-bit arithmetic and is compared every cycle, plus directed
// cases with literal expected values.
module tb_hilo_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 0;

    // Behavioural model state
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    int          m_left;
    logic        m_done;

    hilo_muldiv #(
        .NBITS (32),
        .OPBITS(3),
        .CBITS (6)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .i_Start(start),
        .i_Op   (op),
        .i_RegA (a),
        .i_RegB (b),
        .i_Flush(flush),
        .o_Busy (busy),
        .o_Done (done),
        .o_Hi   (hi),
        .o_Lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference result straight from the arithmetic definitions
    task automatic ref_calc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                            output logic [31:0] rh, output logic [31:0] rl);
        longint          sp;
        longint unsigned up;
        longint          sx;
        longint          sy;
        rh = 32'h0;
        rl = 32'h0;
        case (o)
            3'b000: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                rh = sp[63:32];
                rl = sp[31:0];
            end
            3'b001: begin
                up = {32'h0, x} * {32'h0, y};
                rh = up[63:32];
                rl = up[31:0];
            end
            3'b010: begin
                if (y == 0) begin
                    rh = x;
                    rl = 32'hFFFF_FFFF;
                end else begin
                    sx = longint'($signed(x));
                    sy = longint'($signed(y));
                    sp = sx / sy;
                    rl = sp[31:0];
                    sp = sx % sy;
                    rh = sp[31:0];
                end
            end
            3'b011: begin
                if (y == 0) begin
                    rh = x;
                    rl = 32'hFFFF_FFFF;
                end else begin
                    rl = x / y;
                    rh = x % y;
                end
            end
            default: ;
        endcase
    endtask

    // Cycle-level model: an arithmetic op occupies 33 cycles, then HI/LO update
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi   = 32'h0;
            m_lo   = 32'h0;
            m_left = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                if (flush) begin
                    m_left = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_hi   = p_hi;
                        m_lo   = p_lo;
                        m_done = 1'b1;
                    end
                end
            end else if (start && !flush) begin
                if (op <= 3'b011) begin
                    ref_calc(op, a, b, p_hi, p_lo);
                    m_left = 33;
                end else if (op == 3'b100) begin
                    m_hi = a;
                end else if (op == 3'b101) begin
                    m_lo = a;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_busy", {31'h0, busy}, {31'h0, (m_left > 0)});
            check("model_done", {31'h0, done}, {31'h0, m_done});
            check("model_hi", hi, m_hi);
            check("model_lo", lo, m_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
    endtask

    // Counts cycles with busy high; bounded so a stuck DUT still ends the run
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        if (busy) begin
            check("busy_timeout", {31'h0, busy}, 32'h0);
        end
    endtask

    task automatic arith_case(input string name, input logic [2:0] o, input logic [31:0] x,
                              input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
        int n;
        run_op(o, x, y);
        wait_idle(n);
        check({name, "_latency"}, n, 32'd33);
        check({name, "_done"}, {31'h0, done}, 32'h1);
        check({name, "_hi"}, hi, eh);
        check({name, "_lo"}, lo, el);
        tick();
        check({name, "_done_drop"}, {31'h0, done}, 32'h0);
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] edges [4];
        edges[0] = 32'h0;
        edges[1] = 32'h8000_0000;
        edges[2] = 32'hFFFF_FFFF;
        edges[3] = 32'h1;
        if ($urandom_range(0, 3) == 0) begin
            return edges[$urandom_range(0, 3)];
        end
        return $urandom;
    endfunction

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'b000;
        a     = 32'h0;
        b     = 32'h0;
        tick();
        cmp_en = 1;
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);

        // Directed arithmetic with hand-computed results
        arith_case("mult_7xm3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        arith_case("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        arith_case("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        arith_case("divu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14);
        arith_case("divu_by0", 3'b011, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF);
        arith_case("div_by0", 3'b010, 32'h8000_0005, 32'h0, 32'h8000_0005, 32'hFFFF_FFFF);
        arith_case("div_minneg", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        arith_case("mult_minneg", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);

        // MTHI / MTLO are single-cycle and never raise busy or done
        run_op(3'b100, 32'h1111_1111, 32'h0);
        check("mthi_hi", hi, 32'h1111_1111);
        check("mthi_busy", {31'h0, busy}, 32'h0);
        run_op(3'b101, 32'h2222_2222, 32'h0);
        check("mtlo_lo", lo, 32'h2222_2222);
        check("mtlo_done", {31'h0, done}, 32'h0);

        // Start-while-busy ignored, flush aborts without touching HI/LO
        run_op(3'b000, 32'd5, 32'd9);
        for (int c = 1; c < 10; c++) begin
            if (c == 5) begin
                run_op(3'b010, 32'd77, 32'd3);
            end else begin
                tick();
            end
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {31'h0, busy}, 32'h0);
        check("flush_hi", hi, 32'h1111_1111);
        check("flush_lo", lo, 32'h2222_2222);
        check("flush_done", {31'h0, done}, 32'h0);
        tick();
        check("flush_no_done", {31'h0, done}, 32'h0);

        // Undefined op, and flush colliding with start in IDLE
        run_op(3'b110, 32'hDEAD_BEEF, 32'h1);
        check("undef_busy", {31'h0, busy}, 32'h0);
        check("undef_hi", hi, 32'h1111_1111);
        flush = 1'b1;
        run_op(3'b000, 32'd3, 32'd3);
        flush = 1'b0;
        check("flush_start_busy", {31'h0, busy}, 32'h0);

        run_op(3'b101, 32'h0000_CAFE, 32'h0);
        check("mtlo_cafe", lo, 32'h0000_CAFE);
        check("mtlo_cafe_busy", {31'h0, busy}, 32'h0);

        // Asynchronous reset in the middle of a divide
        run_op(3'b010, 32'd1000, 32'd7);
        for (int c = 0; c < 6; c++) tick();
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_done", {31'h0, done}, 32'h0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Randomized traffic, including stray starts and occasional flushes
        for (int it = 0; it < 80; it++) begin
            run_op(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
            for (int c = 0; c < 36; c++) begin
                flush = ($urandom_range(0, 99) == 0);
                start = ($urandom_range(0, 9) == 0);
                op    = 3'($urandom_range(0, 7));
                a     = rnd_operand();
                b     = rnd_operand();
                tick();
            end
            start = 1'b0;
            flush = 1'b0;
            wait_idle(n);
            tick();
        end

        tick();
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
